// File: rtl/cms_pkg.sv
// rtl/cms_pkg.sv - shared widths, FSM states and sample field positions for the CMS frame streamer
package cms_pkg;

  localparam int SAMPLE_W = 32;
  localparam int LOG2_W   = 3;
  localparam int RESULT_W = 64;

  // Packed complex sample layout: real half on top, imaginary half below.
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STREAM   = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/cms_rd_pipe.sv
// rtl/cms_rd_pipe.sv - one-cycle read-to-valid register stage feeding the CMS unit sample inputs
module cms_rd_pipe
  import cms_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd,
  input  logic [SAMPLE_W-1:0] mem_y,
  input  logic [SAMPLE_W-1:0] mem_y_hat,
  output logic                valid,
  output logic [SAMPLE_W-1:0] y,
  output logic [SAMPLE_W-1:0] y_hat
);

  // Data is zeroed whenever no read was issued so the CMS unit never sees stale samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      y     <= '0;
      y_hat <= '0;
    end else begin
      valid <= rd;
      y     <= rd ? {mem_y[RE_MSB:RE_LSB], mem_y[IM_MSB:IM_LSB]} : '0;
      y_hat <= rd ? {mem_y_hat[RE_MSB:RE_LSB], mem_y_hat[IM_MSB:IM_LSB]} : '0;
    end
  end

endmodule

// File: rtl/cms_frame_streamer.sv
// rtl/cms_frame_streamer.sv - streams a 2^log2 sample frame into the CMS unit and collects its result
module cms_frame_streamer #(
  parameter int SAMPLE_W    = cms_pkg::SAMPLE_W,
  parameter int LOG2_W      = cms_pkg::LOG2_W,
  parameter int ADDR_W      = 7,
  parameter int RESULT_W    = cms_pkg::RESULT_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic                i_start,
  input  logic [LOG2_W-1:0]   i_log2_samples,
  output logic                o_busy,
  output logic                o_mem_rd,
  output logic [ADDR_W-1:0]   o_mem_addr,
  input  logic [SAMPLE_W-1:0] i_mem_y,
  input  logic [SAMPLE_W-1:0] i_mem_y_hat,
  output logic                o_cms_en,
  output logic [LOG2_W-1:0]   o_cms_log2_samples,
  output logic                o_cms_valid,
  output logic [SAMPLE_W-1:0] o_cms_y,
  output logic [SAMPLE_W-1:0] o_cms_y_hat,
  input  logic                i_cms_valid,
  input  logic [RESULT_W-1:0] i_cms_data,
  output logic                o_done,
  output logic                o_timeout,
  output logic [RESULT_W-1:0] o_result
);

  import cms_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_W:0]     addr_cnt;
  logic [ADDR_W:0]     last_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LOG2_W-1:0]   log2_q;

  // One extra counter bit keeps the 128-sample terminal index representable.
  assign last_idx = (CNT_ONE << log2_q) - CNT_ONE;

  assign o_busy             = (state != ST_IDLE);
  assign o_mem_rd           = (state == ST_STREAM);
  assign o_mem_addr         = o_mem_rd ? addr_cnt[ADDR_W-1:0] : '0;
  assign o_cms_en           = (state == ST_STREAM) || (state == ST_DRAIN) || (state == ST_WAIT_RES);
  assign o_cms_log2_samples = log2_q;
  assign o_done             = (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      wait_cnt  <= '0;
      log2_q    <= '0;
      o_timeout <= 1'b0;
      o_result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            log2_q    <= i_log2_samples;
            addr_cnt  <= '0;
            o_timeout <= 1'b0;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          addr_cnt <= addr_cnt + CNT_ONE;
          if (addr_cnt == last_idx) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          wait_cnt <= wait_cnt + WAIT_ONE;
          // A result landing on the terminal count still wins over the timeout.
          if (i_cms_valid) begin
            o_result <= i_cms_data;
            state    <= ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            o_timeout <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cms_rd_pipe u_rd_pipe (
    .clk       (i_clk),
    .rst_n     (i_arst_n),
    .rd        (o_mem_rd),
    .mem_y     (i_mem_y),
    .mem_y_hat (i_mem_y_hat),
    .valid     (o_cms_valid),
    .y         (o_cms_y),
    .y_hat     (o_cms_y_hat)
  );

endmodule
